// File: rtl/rotate_clockwise_pkg.sv
// Shared types and constants for the Tetris piece-control datapath.
// Piece descriptor layout, piece indices and the default playfield width.
package rotate_clockwise_pkg;

    localparam int BOARD_WIDTH = 10;
    localparam int SHAPE_DIM   = 4;

    localparam logic [2:0] TETROMINO_I_IDX = 3'd0;
    localparam logic [2:0] TETROMINO_O_IDX = 3'd1;
    localparam logic [2:0] TETROMINO_T_IDX = 3'd2;
    localparam logic [2:0] TETROMINO_S_IDX = 3'd3;
    localparam logic [2:0] TETROMINO_Z_IDX = 3'd4;
    localparam logic [2:0] TETROMINO_J_IDX = 3'd5;
    localparam logic [2:0] TETROMINO_L_IDX = 3'd6;

    typedef struct packed {
        logic [2:0] data;
    } tetromino_idx_t;

    typedef struct packed {
        logic signed [5:0] x;
        logic signed [5:0] y;
    } coordinate_t;

    // One 4x4 mask per rotation; row 0 is the MSB nibble, column 0 the MSB of a row.
    typedef struct packed {
        logic [0:3][15:0] data;
    } tetromino_shapes_t;

    typedef struct packed {
        tetromino_idx_t    idx;
        logic [1:0]        rotation;
        coordinate_t       coordinate;
        tetromino_shapes_t tetromino;
    } tetromino_ctrl;

endpackage

// File: rtl/rotate_clockwise_shape_col_extent.sv
// Combinational column extent of a 4x4 shape mask: leftmost/rightmost
// occupied columns, plus a flag for an empty mask.
module shape_col_extent
    import rotate_clockwise_pkg::*;
(
    input  logic [15:0] mask_i,
    output logic [1:0]  cmin_o,
    output logic [1:0]  cmax_o,
    output logic        empty_o
);

    logic [SHAPE_DIM-1:0] col_occ;

    always_comb begin
        for (int c = 0; c < SHAPE_DIM; c++) begin
            col_occ[c] = mask_i[15-c] | mask_i[11-c] | mask_i[7-c] | mask_i[3-c];
        end
    end

    always_comb begin
        cmin_o = '0;
        cmax_o = '0;
        // Descending scan leaves the lowest occupied column in cmin_o.
        for (int c = SHAPE_DIM - 1; c >= 0; c--) begin
            if (col_occ[c]) cmin_o = 2'(c);
        end
        for (int c = 0; c < SHAPE_DIM; c++) begin
            if (col_occ[c]) cmax_o = 2'(c);
        end
        empty_o = ~|col_occ;
    end

endmodule

// File: rtl/rotate_clockwise.sv
// Registered clockwise quarter-turn of the active piece descriptor, 1-cycle latency.
// Define ROTATE_WALL_KICK_EN to add a horizontal boundary kick on the new shape.
module rotate_clockwise
    import rotate_clockwise_pkg::*;
#(
    parameter int BOARD_W = BOARD_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  tetromino_ctrl t_in,
    output logic          valid_out,
    output tetromino_ctrl t_out
);

    // Handshake: valid_in=1 samples t_in at the edge; valid_out pulses one cycle
    // later with the result. No ready/backpressure; t_out holds between requests.
    tetromino_ctrl    t_d, t_q;
    logic             valid_q;
    logic [1:0]       rot_next;
    logic signed [5:0] x_next;

    assign rot_next = t_in.rotation + 2'd1;

`ifdef ROTATE_WALL_KICK_EN
    logic [15:0]       new_mask;
    logic [1:0]        cmin, cmax;
    logic              empty;
    logic signed [7:0] x_ext, left_pos, right_pos, limit;

    assign new_mask = t_in.tetromino.data[rot_next];

    shape_col_extent u_extent (
        .mask_i  (new_mask),
        .cmin_o  (cmin),
        .cmax_o  (cmax),
        .empty_o (empty)
    );

    always_comb begin
        x_ext     = {{2{t_in.coordinate.x[5]}}, t_in.coordinate.x};
        left_pos  = x_ext + $signed({6'b0, cmin});
        right_pos = x_ext + $signed({6'b0, cmax});
        limit     = 8'(BOARD_W - 1);
        x_next    = t_in.coordinate.x;
        if (!empty) begin
            if (left_pos[7]) begin
                x_next = 6'd0 - {4'b0, cmin};
            end else if (right_pos > limit) begin
                x_next = 6'(BOARD_W - 1) - {4'b0, cmax};
            end
        end
    end
`else
    assign x_next = t_in.coordinate.x;
`endif

    always_comb begin
        t_d              = t_in;
        t_d.rotation     = rot_next;
        t_d.coordinate.x = x_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_in;
            if (valid_in) t_q <= t_d;
        end
    end

    assign t_out     = t_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_rotate_clockwise.sv
// Self-checking bench for rotate_clockwise: directed test-plan steps then
// randomized requests against a behavioural rotation model.
module tb_rotate_clockwise;
    import rotate_clockwise_pkg::*;

    localparam int BW = 10;

    logic          clk;
    logic          rst;
    logic          valid_in;
    tetromino_ctrl t_in;
    logic          valid_out;
    tetromino_ctrl t_out;

    int checks = 0;
    int errors = 0;

    tetromino_ctrl exp_q[$];
    tetromino_ctrl held;
    logic          exp_v;

    rotate_clockwise #(.BOARD_W(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .t_in      (t_in),
        .valid_out (valid_out),
        .t_out     (t_out)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural reference: rotate, optionally kick against the walls
    function automatic tetromino_ctrl ref_rotate(input tetromino_ctrl t);
        tetromino_ctrl r;
        int nr;
        r  = t;
        nr = (int'(t.rotation) + 1) % 4;
        r.rotation = 2'(nr);
`ifdef ROTATE_WALL_KICK_EN
        begin
            logic [15:0] m;
            int lo, hi, x;
            m  = t.tetromino.data[nr];
            lo = 99;
            hi = -1;
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    if (m[15 - 4*row - col]) begin
                        if (col < lo) lo = col;
                        if (col > hi) hi = col;
                    end
            x = int'($signed(t.coordinate.x));
            if (hi >= 0) begin
                if (x + lo < 0) x = -lo;
                else if (x + hi > BW - 1) x = BW - 1 - hi;
            end
            r.coordinate.x = 6'(x);
        end
`endif
        return r;
    endfunction

    function automatic tetromino_ctrl mk(input int idx, input int rot, input int x, input int y,
                                         input logic [15:0] m0, input logic [15:0] m1,
                                         input logic [15:0] m2, input logic [15:0] m3);
        tetromino_ctrl t;
        t.idx.data          = 3'(idx);
        t.rotation          = 2'(rot);
        t.coordinate.x      = 6'(x);
        t.coordinate.y      = 6'(y);
        t.tetromino.data[0] = m0;
        t.tetromino.data[1] = m1;
        t.tetromino.data[2] = m2;
        t.tetromino.data[3] = m3;
        return t;
    endfunction

    // driver + scoreboard: drive one cycle, then check the registered outputs
    task automatic step(input logic r, input logic v, input tetromino_ctrl t, input string tag);
        rst      = r;
        valid_in = v;
        t_in     = t;
        if (!r && v) exp_q.push_back(ref_rotate(t));
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            held  = '0;
            exp_v = 1'b0;
        end else if (v) begin
            held  = exp_q.pop_front();
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        checks++;
        assert (valid_out === exp_v) else begin
            errors++;
            $error("FAIL %s valid_out got %0b want %0b", tag, valid_out, exp_v);
        end
        checks++;
        assert (t_out === held) else begin
            errors++;
            $error("FAIL %s t_out got %h want %h", tag, t_out, held);
        end
    endtask

    task automatic check_field(input string tag, input int got, input int want);
        checks++;
        assert (got == want) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    tetromino_ctrl i_pc, o_pc, t_pc, rnd;

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        t_in     = '0;
        held     = '0;
        exp_v    = 1'b0;

        step(1'b1, 1'b0, '0, "reset0");
        step(1'b1, 1'b0, '0, "reset1");

        // 1: I piece rotation 0 -> 1
        i_pc = mk(TETROMINO_I_IDX, 0, 5, 5, 16'h0F00, 16'h2222, 16'h00F0, 16'h4444);
        step(1'b0, 1'b1, i_pc, "i_rot0");
        check_field("i_rot0_rotation", int'(t_out.rotation), 1);
        check_field("i_rot0_x", int'($signed(t_out.coordinate.x)), 5);
        step(1'b0, 1'b0, i_pc, "i_pulse_end");

        // 2: wrap 3 -> 0
        i_pc.rotation = 2'd3;
        step(1'b0, 1'b1, i_pc, "i_wrap");
        check_field("i_wrap_rotation", int'(t_out.rotation), 0);

        // 3: O piece still rotates
        o_pc = mk(TETROMINO_O_IDX, 0, 4, 0, 16'h0660, 16'h0660, 16'h0660, 16'h0660);
        step(1'b0, 1'b1, o_pc, "o_rot");
        check_field("o_rotation", int'(t_out.rotation), 1);

        // 4: T piece back-to-back
        t_pc = mk(TETROMINO_T_IDX, 0, 3, 7, 16'h4E00, 16'h4C40, 16'h0E40, 16'h4640);
        for (int k = 0; k < 4; k++) begin
            t_pc.rotation = 2'(k);
            step(1'b0, 1'b1, t_pc, "t_b2b");
            check_field("t_b2b_rotation", int'(t_out.rotation), (k + 1) % 4);
        end

        // 5: hold when idle, then reset beats a simultaneous request
        step(1'b0, 1'b0, '0, "hold_nonzero");
        step(1'b1, 1'b1, t_pc, "rst_with_valid");
        step(1'b0, 1'b0, t_pc, "hold_zero");
        step(1'b0, 1'b0, t_pc, "hold_zero2");

`ifdef ROTATE_WALL_KICK_EN
        // 6: boundary kick on the I piece's horizontal mask
        i_pc = mk(TETROMINO_I_IDX, 1, -1, 5, 16'h0F00, 16'h2222, 16'h00F0, 16'h4444);
        step(1'b0, 1'b1, i_pc, "kick_left");
        check_field("kick_left_x", int'($signed(t_out.coordinate.x)), 0);
        i_pc.coordinate.x = 6'sd8;
        step(1'b0, 1'b1, i_pc, "kick_right");
        check_field("kick_right_x", int'($signed(t_out.coordinate.x)), 6);
`endif

        // randomized traffic, sparse resets, masks sometimes empty
        for (int n = 0; n < 300; n++) begin
            rnd = mk(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15)) - 3, int'($urandom_range(0, 20)),
                     16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 7) == 0) rnd.tetromino.data[(int'(rnd.rotation) + 1) % 4] = 16'h0000;
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), rnd, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
